// File: rtl/acemf_cfg_pkg.sv
// acemf_cfg_pkg: shared constants and state types for the detector configuration AXI4-Lite slave.
// Register word offsets, CTRL bit positions, AXI response codes and FSM encodings live here.
package acemf_cfg_pkg;

  // Word index of each register (byte address bits [3:2])
  localparam logic [1:0] OFF_MAT  = 2'd0;
  localparam logic [1:0] OFF_SR   = 2'd1;
  localparam logic [1:0] OFF_SRS  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  // CTRL bit positions
  localparam int CTRL_DEBUG_EN    = 0;
  localparam int CTRL_PTR_CLR     = 1;
  localparam int CTRL_MAT_FULL    = 8;
  localparam int CTRL_SR_FULL     = 9;
  localparam int CTRL_SRS_WRITTEN = 10;
  localparam int CTRL_CFG_DONE    = 11;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Default geometry
  localparam int DEF_NUM_BANDS = 16;
  localparam int DEF_MAT_DEPTH = DEF_NUM_BANDS * DEF_NUM_BANDS;
  localparam int DEF_SR_DEPTH  = DEF_NUM_BANDS;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_W,
    W_EXEC,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/acemf_cfg_ptr.sv
// acemf_cfg_ptr: saturating BRAM write pointer. Counts pushes up to DEPTH and then holds;
// full is asserted while the pointer sits at DEPTH. clr returns it to zero and wins over push.
module acemf_cfg_ptr #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr,
  output logic             full
);

  assign full = (ptr == PTR_W'(DEPTH));

  // Pointer register: clear has priority, pushes beyond full are ignored
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/acemf_cfg_axil_slave.sv
// acemf_cfg_axil_slave: AXI4-Lite responder for the detector configuration path.
// Writes to MAT_DATA/SR_DATA push words into the matrix and sR BRAMs through saturating
// pointers; SRS and CTRL are static registers. Reads return pointers, SRS and status.
// Optional build macro CFG_WSTRB_EN: SRS/CTRL honour wstrb per byte and MAT/SR pushes
// with a partial strobe are refused with SLVERR. Without it every write is full-word.
module acemf_cfg_axil_slave
  import acemf_cfg_pkg::*;
#(
  parameter int NUM_BANDS       = DEF_NUM_BANDS,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 4,
  localparam int MAT_DEPTH = NUM_BANDS * NUM_BANDS,
  localparam int MAT_AW    = $clog2(MAT_DEPTH),
  localparam int SR_AW     = $clog2(NUM_BANDS),
  localparam int STRB_W    = BRAM_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [BRAM_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0]          s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [BRAM_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic                       mat_we,
  output logic [MAT_AW-1:0]          mat_addr,
  output logic [BRAM_DATA_WIDTH-1:0] mat_wdata,
  output logic                       sr_we,
  output logic [SR_AW-1:0]           sr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] sr_wdata,
  output logic [BRAM_DATA_WIDTH-1:0] srs,
  output logic                       debug_en,
  output logic                       cfg_done
);

  localparam int MAT_PW = $clog2(MAT_DEPTH + 1);
  localparam int SR_PW  = $clog2(NUM_BANDS + 1);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                       active;
  logic [1:0]                 aw_idx;
  logic [BRAM_DATA_WIDTH-1:0] wdata_q;
  logic [1:0]                 bresp_q;
  logic                       srs_written;
  logic [BRAM_DATA_WIDTH-1:0] srs_new;
  logic                       strb_full;
  logic                       ctrl_b0_wr;
  logic [BRAM_DATA_WIDTH-1:0] rd_word;

  logic [MAT_PW-1:0] mat_ptr;
  logic [SR_PW-1:0]  sr_ptr;
  logic mat_full, sr_full;

  logic aw_hs, w_hs, ar_hs, exec;
  logic mat_sel, sr_sel, srs_wr, ctrl_wr, ptr_clr, push_err;

  // Readies stay low while in reset and for the first cycle after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) active <= 1'b0;
    else         active <= 1'b1;
  end

  assign s_axi_awready = active && (wr_state == W_IDLE || wr_state == W_W);
  assign s_axi_wready  = active && (wr_state == W_IDLE || wr_state == W_AW);
  assign s_axi_bvalid  = (wr_state == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = active && (rd_state == R_IDLE);
  assign s_axi_rvalid  = (rd_state == R_DATA);
  assign s_axi_rresp   = RESP_OKAY;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Write FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_state <= W_IDLE;
    else         wr_state <= wr_next;
  end

  // Write FSM next state: collect both halves, execute for one cycle, then respond
  // NOTE: the default is assigned first so no path through the case leaves wr_next unassigned (no latch).
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_EXEC;
        else if (aw_hs)    wr_next = W_AW;
        else if (w_hs)     wr_next = W_W;
      end
      W_AW:    if (w_hs)  wr_next = W_EXEC;
      W_W:     if (aw_hs) wr_next = W_EXEC;
      W_EXEC:  wr_next = W_RESP;
      W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Capture address and data halves as each is accepted
  // NOTE: these holding registers are cleared on reset as well, so a dropped transfer leaves no stale value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_idx  <= '0;
      wdata_q <= '0;
    end else begin
      if (aw_hs) aw_idx  <= s_axi_awaddr[3:2];
      if (w_hs)  wdata_q <= s_axi_wdata;
    end
  end

`ifdef CFG_WSTRB_EN
  logic [STRB_W-1:0] wstrb_q;

  // Strobe holding register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   wstrb_q <= '0;
    else if (w_hs) wstrb_q <= s_axi_wstrb;
  end

  // Byte-merge the SRS update; pushes need a full-word strobe
  always_comb begin
    srs_new = srs;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) srs_new[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end
  assign strb_full  = &wstrb_q;
  assign ctrl_b0_wr = wstrb_q[0];
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
  assign srs_new    = wdata_q;
  assign strb_full  = 1'b1;
  assign ctrl_b0_wr = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                       s_axi_wstrb};
`endif

  // Register-write decode, active only in the single execute cycle
  assign exec     = (wr_state == W_EXEC);
  assign mat_sel  = exec && (aw_idx == OFF_MAT);
  assign sr_sel   = exec && (aw_idx == OFF_SR);
  assign srs_wr   = exec && (aw_idx == OFF_SRS);
  assign ctrl_wr  = exec && (aw_idx == OFF_CTRL);
  assign ptr_clr  = ctrl_wr && ctrl_b0_wr && wdata_q[CTRL_PTR_CLR];
  assign mat_we   = mat_sel && !mat_full && strb_full;
  assign sr_we    = sr_sel && !sr_full && strb_full;
  assign push_err = (mat_sel && !mat_we) || (sr_sel && !sr_we);

  assign mat_addr  = mat_ptr[MAT_AW-1:0];
  assign mat_wdata = wdata_q;
  assign sr_addr   = sr_ptr[SR_AW-1:0];
  assign sr_wdata  = wdata_q;
  assign cfg_done  = mat_full && sr_full && srs_written;

  acemf_cfg_ptr #(.DEPTH(MAT_DEPTH), .PTR_W(MAT_PW)) u_mat_ptr (
    .clk(clk), .resetn(resetn), .push(mat_we), .clr(ptr_clr), .ptr(mat_ptr), .full(mat_full)
  );

  acemf_cfg_ptr #(.DEPTH(NUM_BANDS), .PTR_W(SR_PW)) u_sr_ptr (
    .clk(clk), .resetn(resetn), .push(sr_we), .clr(ptr_clr), .ptr(sr_ptr), .full(sr_full)
  );

  // Static registers and the write response code
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      srs         <= '0;
      srs_written <= 1'b0;
      debug_en    <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      if (exec)    bresp_q <= push_err ? RESP_SLVERR : RESP_OKAY;
      if (srs_wr)  srs <= srs_new;
      if (ptr_clr)     srs_written <= 1'b0;
      else if (srs_wr) srs_written <= 1'b1;
      if (ctrl_wr && ctrl_b0_wr) debug_en <= wdata_q[CTRL_DEBUG_EN];
    end
  end

  // Read mux; unmapped bits read as zero
  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[3:2])
      OFF_MAT:  rd_word[MAT_PW-1:0] = mat_ptr;
      OFF_SR:   rd_word[SR_PW-1:0]  = sr_ptr;
      OFF_SRS:  rd_word = srs;
      default: begin
        rd_word[CTRL_DEBUG_EN]    = debug_en;
        rd_word[CTRL_MAT_FULL]    = mat_full;
        rd_word[CTRL_SR_FULL]     = sr_full;
        rd_word[CTRL_SRS_WRITTEN] = srs_written;
        rd_word[CTRL_CFG_DONE]    = cfg_done;
      end
    endcase
  end

  // Read FSM next state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Read FSM state and registered read data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state    <= R_IDLE;
      s_axi_rdata <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) s_axi_rdata <= rd_word;
    end
  end

endmodule
